// File: rtl/globals_pkg.sv
// Shared definitions for the shift datapath: word width, shifter op codes
// and the sequencer FSM state type.
package globals;

  localparam int WORDLEN = 16;

  // Single-step shifter operation codes; 3'd6 and 3'd7 are undefined.
  localparam logic [2:0] SHFT_NIL = 3'd0;
  localparam logic [2:0] SHFT_SHL = 3'd1;
  localparam logic [2:0] SHFT_SHR = 3'd2;
  localparam logic [2:0] SHFT_ROL = 3'd3;
  localparam logic [2:0] SHFT_ROR = 3'd4;
  localparam logic [2:0] SHFT_SRA = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/shifter.sv
// Single-step shifter. out3 is the shifted word, out2 the carry and out1
// flags a zero input word. The carry is the bit crossing the MSB boundary:
// the bit leaving on SHL/ROL, the bit wrapping in on ROR, and the zero fill
// on SHR/SRA (SRA zero-fills its MSB, so it behaves as SHR).
module shifter #(
  parameter int WORDLEN = globals::WORDLEN
) (
  input  logic [2:0]         input1,
  input  logic [WORDLEN-1:0] input2,
  output logic               out1,
  output logic               out2,
  output logic [WORDLEN-1:0] out3
);
  import globals::*;

  assign out1 = (input2 == '0);

  // Decode the op into one shift step; undefined ops yield 0 with carry 0.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    out3 = '0;
    out2 = 1'b0;
    case (input1)
      SHFT_NIL: out3 = input2;
      SHFT_SHL: begin
        out3 = {input2[WORDLEN-2:0], 1'b0};
        out2 = input2[WORDLEN-1];
      end
      SHFT_SHR, SHFT_SRA: out3 = {1'b0, input2[WORDLEN-1:1]};
      SHFT_ROL: begin
        out3 = {input2[WORDLEN-2:0], input2[WORDLEN-1]};
        out2 = input2[WORDLEN-1];
      end
      SHFT_ROR: begin
        out3 = {input2[0], input2[WORDLEN-1:1]};
        out2 = input2[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts one request, iterates the single-step
// shifter amt times feeding each result back, then returns the final word,
// carry and zero flag over a valid/ready response port.
module shift_sequencer #(
  parameter int WORDLEN = globals::WORDLEN,
  parameter int AMTW    = $clog2(WORDLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WORDLEN-1:0] req_data,
  input  logic [AMTW-1:0]    req_amt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORDLEN-1:0] rsp_data,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               busy
);
  import globals::*;

  seq_state_t         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WORDLEN-1:0] data_q, data_d;
  logic [AMTW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;

  logic [WORDLEN-1:0] sh_data;
  logic               sh_carry;
  logic               sh_zero_unused;

  shifter #(.WORDLEN(WORDLEN)) u_shifter (
    .input1 (op_q),
    .input2 (data_q),
    .out1   (sh_zero_unused),
    .out2   (sh_carry),
    .out3   (sh_data)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: all registers are cleared because rsp_data/rsp_zero expose data_q directly.
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Next-state and datapath update: load on accept, step in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          data_d  = req_data;
          cnt_d   = req_amt;
          carry_d = 1'b0;
          state_d = (req_amt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        data_d  = sh_data;
        carry_d = sh_carry;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == AMTW'(1)) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no path from request/response inputs.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = (data_q == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a scoreboard of expected responses
// is filled at request time and drained by a monitor on response handshakes.
module tb_shift_sequencer;
  import globals::*;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_data;
  logic [AW-1:0] req_amt;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          busy;

  shift_sequencer #(.WORDLEN(W), .AMTW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         carry;
  } res_t;

  res_t sb_q[$];
  res_t mon_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference single step, written with shift operators.
  function automatic res_t step(input logic [2:0] op, input res_t r);
    res_t n;
    n.data  = '0;
    n.carry = 1'b0;
    case (op)
      SHFT_NIL: n.data = r.data;
      SHFT_SHL: begin n.data = r.data << 1; n.carry = r.data[W-1]; end
      SHFT_SHR, SHFT_SRA: n.data = r.data >> 1;
      SHFT_ROL: begin n.data = (r.data << 1) | (r.data >> (W-1)); n.carry = r.data[W-1]; end
      SHFT_ROR: begin n.data = (r.data >> 1) | (r.data << (W-1)); n.carry = r.data[0]; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] d, input int n);
    res_t r;
    r.data  = d;
    r.carry = 1'b0;
    for (int i = 0; i < n; i++) r = step(op, r);
    return r;
  endfunction

  // Monitor: compare each completed response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_data", rsp_data, mon_exp.data);
        check("sb_carry", rsp_carry, mon_exp.carry);
        check("sb_zero", rsp_zero, (mon_exp.data == '0));
      end
    end
  end

  // Called at posedge+1; returns at acceptance edge +1.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input int amt);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", req_ready, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_amt   = AW'(amt);
    sb_q.push_back(model(op, d, amt));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_data  = W'($urandom);
    req_amt   = AW'($urandom);
  endtask

  // Follow the run cycle by cycle; optionally present a competing request mid-run.
  task automatic run_check(input logic [2:0] op, input logic [W-1:0] d, input int amt,
                           input string tag, input bit poke);
    res_t r;
    for (int k = 0; k <= amt; k++) begin
      @(negedge clk);
      r = model(op, d, k);
      check($sformatf("%s_data_k%0d", tag, k), rsp_data, r.data);
      check($sformatf("%s_carry_k%0d", tag, k), rsp_carry, r.carry);
      check($sformatf("%s_ready_k%0d", tag, k), req_ready, 32'd0);
      check($sformatf("%s_busy_k%0d", tag, k), busy, 32'd1);
      check($sformatf("%s_valid_k%0d", tag, k), rsp_valid, (k == amt) ? 32'd1 : 32'd0);
      if (poke && k == 1) begin
        req_valid = 1'b1;
        req_op    = SHFT_SHL;
        req_data  = 16'hFFFF;
        req_amt   = 4'd3;
      end
      if (poke && k == amt - 1) req_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 32'd1);
    check({tag, "_rsp_valid"}, rsp_valid, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_carry"}, rsp_carry, 32'd0);
    check({tag, "_rsp_zero"}, rsp_zero, 32'd1);
    check({tag, "_busy"}, busy, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t hold;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHL by 1: response in the cycle after edge T+1.
    issue(SHFT_SHL, 16'h8001, 1);
    run_check(SHFT_SHL, 16'h8001, 1, "shl", 1'b0);
    check("shl_const_data", rsp_data, 32'h0002);
    check("shl_const_carry", rsp_carry, 32'd1);
    check("shl_const_zero", rsp_zero, 32'd0);
    @(posedge clk); #1;

    // ROR by 4: intermediate carries 1,0,0,0 are checked inside run_check.
    issue(SHFT_ROR, 16'h0001, 4);
    run_check(SHFT_ROR, 16'h0001, 4, "ror", 1'b0);
    check("ror_const_data", rsp_data, 32'h1000);
    check("ror_const_carry", rsp_carry, 32'd0);
    @(posedge clk); #1;

    // SHR by 8 down to zero, with a competing request presented during RUN.
    issue(SHFT_SHR, 16'h00F0, 8);
    run_check(SHFT_SHR, 16'h00F0, 8, "shr", 1'b1);
    check("shr_const_data", rsp_data, 32'h0000);
    check("shr_const_zero", rsp_zero, 32'd1);
    check("shr_const_carry", rsp_carry, 32'd0);
    @(posedge clk); #1;

    // Amount 0: response in the cycle after the accept edge, data unchanged.
    issue(SHFT_ROL, 16'h1234, 0);
    run_check(SHFT_ROL, 16'h1234, 0, "amt0", 1'b0);
    check("amt0_const_data", rsp_data, 32'h1234);
    check("amt0_const_carry", rsp_carry, 32'd0);
    @(posedge clk); #1;

    // NIL and undefined op.
    issue(SHFT_NIL, 16'h5A5A, 3);
    run_check(SHFT_NIL, 16'h5A5A, 3, "nil", 1'b0);
    @(posedge clk); #1;
    issue(3'd7, 16'hBEEF, 2);
    run_check(3'd7, 16'hBEEF, 2, "undef", 1'b0);
    check("undef_const_data", rsp_data, 32'h0000);
    @(posedge clk); #1;

    // Backpressure: response held for 3 cycles, then released.
    rsp_ready = 1'b0;
    issue(SHFT_SRA, 16'hA5C3, 3);
    run_check(SHFT_SRA, 16'hA5C3, 3, "sra", 1'b0);
    check("sra_const_data", rsp_data, 32'h14B8);
    hold = model(SHFT_SRA, 16'hA5C3, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), rsp_valid, 32'd1);
      check($sformatf("bp_data_%0d", i), rsp_data, hold.data);
      check($sformatf("bp_carry_%0d", i), rsp_carry, hold.carry);
      check($sformatf("bp_zero_%0d", i), rsp_zero, (hold.data == '0));
      check($sformatf("bp_req_ready_%0d", i), req_ready, 32'd0);
      check($sformatf("bp_busy_%0d", i), busy, 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_req_ready", req_ready, 32'd1);
    check("bp_release_rsp_valid", rsp_valid, 32'd0);
    check("bp_release_busy", busy, 32'd0);

    // Back-to-back requests at the minimum interval.
    issue(SHFT_SHL, 16'h4001, 2);
    run_check(SHFT_SHL, 16'h4001, 2, "b2b0", 1'b0);
    @(posedge clk); #1;
    issue(SHFT_ROL, 16'hC003, 5);
    run_check(SHFT_ROL, 16'hC003, 5, "b2b1", 1'b0);
    @(posedge clk); #1;

    // Reset mid-run abandons the operation.
    issue(SHFT_ROL, 16'h8000, 10);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    void'(sb_q.pop_back());
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rsp_%0d", i), rsp_valid, 32'd0);
    end
    check("midrst_idle_ready", req_ready, 32'd1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit shift controller wrapped around the single-step `shifter`. It accepts a request carrying an operation code, a data word and a shift amount. It then drives the shifter once per cycle, feeding each result back in, until the amount is exhausted. The final word, carry and zero flag are returned over a valid/ready response port. It sits between the ALU issue logic and the shifter, so the ALU gets shift-by-N without a barrel shifter.

## Interface
Parameters:
- `WORDLEN`, default `globals::WORDLEN` (16): data width.
- `AMTW`, default `$clog2(WORDLEN)` (4): shift-amount width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  3  shift op, one of the `globals::SHFT_*` codes.
- `req_data`  in  WORDLEN  operand.
- `req_amt`  in  AMTW  number of steps, 0..WORDLEN-1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  WORDLEN  shifted word.
- `rsp_carry`  out  1  carry from the last step.
- `rsp_zero`  out  1  high when `rsp_data == 0`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`: latch `op_q`, `data_q` = `req_data`, `cnt_q` = `req_amt`, `carry_q` = 0.
  - Next state is RUN if `req_amt != 0`, otherwise DONE.
- **RUN**
  - The shifter is driven with `op_q` and `data_q`.
  - Each cycle: `data_q` ← shifter `out3`, `carry_q` ← shifter `out2`, `cnt_q` ← `cnt_q - 1`.
  - When `cnt_q == 1`, next state is DONE.
- **DONE**
  - `rsp_valid` = 1.
  - `rsp_data` = `data_q`, `rsp_carry` = `carry_q`, `rsp_zero` = (`data_q == 0`).
  - On `rsp_ready`, go to IDLE.
- Per-step semantics are exactly those of `shifter`, including:
  - SHFT_SRA zero-fills the MSB.
  - Undefined op codes produce 0 with carry 0.
  - SHFT_NIL leaves the data unchanged with carry 0.
  - The bench reference model is an N-fold application of the shifter step function.
- Amount 0: the result equals `req_data`, carry = 0, and no shifter step is taken.
- The shifter's `out1` (input-zero flag) is unused. `rsp_zero` is computed on the final word.
- Request inputs are sampled only at acceptance. Changes afterwards have no effect.
- While busy, `req_ready` = 0. There is one outstanding request at most, with no queueing.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State goes to IDLE; `data_q`, `carry_q`, `cnt_q` and `op_q` are cleared.
  - Outputs after reset: `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_carry` = 0, `rsp_zero` = 1, `busy` = 0.
- Reset asserted during RUN or DONE abandons the operation. No response is produced, even if `rsp_ready` is high that cycle.
- Latency for a request accepted at edge T:
  - RUN occupies edges T+1 .. T+amt.
  - `rsp_valid` is first high in the cycle after edge T+amt.
  - For amt 0, `rsp_valid` is high in the cycle after edge T.
- The response handshake completes at the first edge with `rsp_valid && rsp_ready`. `req_ready` returns high in the cycle after that.
- Minimum accept-to-accept interval is amt+2 cycles.
- Backpressure: while `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable and `busy` stays 1.
- All outputs are registered or decoded from registered state. There is no combinational path from `req_*` or `rsp_ready` to any output.

## Structure
- Package `globals` supplies `WORDLEN` and the `SHFT_*` codes.
- Add to `globals`: a typedef `seq_state_t` for the FSM state enum {IDLE, RUN, DONE}.
- Sub-module: one instance of the existing `shifter`, with input1 = `op_q`, input2 = `data_q`.
- All other logic lives in `shift_sequencer`.

## Test plan
- **SHL:** op SHFT_SHL, data 0x8001, amt 1 → `rsp_data` 0x0002, carry 1, zero 0; `rsp_valid` first high in the cycle after edge T+1.
- **ROR:** op SHFT_ROR, data 0x0001, amt 4 → `rsp_data` 0x1000, carry 0; the bench checks that intermediate carries are 1,0,0,0.
- **SHR to zero:** op SHFT_SHR, data 0x00F0, amt 8 → `rsp_data` 0x0000, zero 1, carry 0, response after 8 RUN cycles; a second request presented during RUN is not accepted (`req_ready` low).
- **Amount 0:** op SHFT_ROL, data 0x1234, amt 0 → `rsp_data` 0x1234, carry 0, `rsp_valid` in the cycle after edge T.
- **Backpressure:** hold `rsp_ready` low for 3 cycles → `rsp_*` stable, `req_ready` 0; release → `req_ready` 1 in the cycle after the handshake edge, and back-to-back requests are accepted.
- **Reset mid-run:** drop `rst_n` mid-RUN (SHFT_ROL, 0x8000, amt 10) → IDLE after that edge, `rsp_valid` never asserts, all outputs at their reset values.
